// File: rtl/param_fifo.sv
// Synchronous single-clock FIFO with registered read data, occupancy count and status pulses.
// Latency: write visible to a read on the next cycle; dout valid one cycle after an accepted rd_en.
// Backpressure: writes at full and reads at empty are dropped and flagged by wr_err / rd_err.
module param_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH_LOG2 = 3,
    parameter int AF_LEVEL   = (1 << DEPTH_LOG2) - 1,
    parameter int AE_LEVEL   = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [DEPTH_LOG2:0]   data_count,
    output logic                  wr_ack,
    output logic                  wr_err,
    output logic                  rd_ack,
    output logic                  rd_err
);

    localparam int CW    = DEPTH_LOG2 + 1;
    localparam int DEPTH = 1 << DEPTH_LOG2;

    // Thresholds pre-sized to the count width so the flag compares stay width-clean.
    localparam logic [CW-1:0]         DEPTH_CNT = CW'(DEPTH);
    localparam logic [CW-1:0]         AF_CNT    = CW'(AF_LEVEL);
    localparam logic [CW-1:0]         AE_CNT    = CW'(AE_LEVEL);
    localparam logic [CW-1:0]         CNT_ZERO  = '0;
    localparam logic [CW-1:0]         CNT_ONE   = CW'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = DEPTH_LOG2'(1);

    // Storage and state registers.
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  wr_ack_q, wr_ack_d;
    logic                  wr_err_q, wr_err_d;
    logic                  rd_ack_q, rd_ack_d;
    logic                  rd_err_q, rd_err_d;

    // Accept decisions; both look only at the registered (pre-edge) count.
    logic wr_accept;
    logic rd_accept;

    // Decide which requests are accepted this cycle.
    always_comb begin
        wr_accept = wr_en && (count_q != DEPTH_CNT);
        rd_accept = rd_en && (count_q != CNT_ZERO);
    end

    // Pointer and occupancy next-state; pointers wrap naturally at DEPTH.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_accept) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (rd_accept) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        unique case ({wr_accept, rd_accept})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // Memory next-state: only the slot under wr_ptr changes, and only on an accepted write.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end
        if (wr_accept) begin
            mem_d[wr_ptr_q] = din;
        end
    end

    // Read data and status pulses; dout holds unless a read is accepted.
    always_comb begin
        dout_d   = rd_accept ? mem_q[rd_ptr_q] : dout_q;
        wr_ack_d = wr_accept;
        wr_err_d = wr_en && !wr_accept;
        rd_ack_d = rd_accept;
        rd_err_d = rd_en && !rd_accept;
    end

    // Control and output registers, cleared asynchronously by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            dout_q   <= '0;
            wr_ack_q <= 1'b0;
            wr_err_q <= 1'b0;
            rd_ack_q <= 1'b0;
            rd_err_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            dout_q   <= dout_d;
            wr_ack_q <= wr_ack_d;
            wr_err_q <= wr_err_d;
            rd_ack_q <= rd_ack_d;
            rd_err_q <= rd_err_d;
        end
    end

    // Storage array carries no reset; stale contents are unreachable once the pointers clear.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    // Level flags are decoded straight from the registered count.
    always_comb begin
        full         = (count_q == DEPTH_CNT);
        empty        = (count_q == CNT_ZERO);
        almost_full  = (count_q >= AF_CNT);
        almost_empty = (count_q <= AE_CNT);
    end

    assign dout       = dout_q;
    assign data_count = count_q;
    assign wr_ack     = wr_ack_q;
    assign wr_err     = wr_err_q;
    assign rd_ack     = rd_ack_q;
    assign rd_err     = rd_err_q;

endmodule

// File: doc/param_fifo.md
PARAM_FIFO -- requirements
Module: param_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, data word width in bits (1..64).
REQ-002 SHALL have parameter DEPTH_LOG2, default 3, log2 of entry count; DEPTH = 2**DEPTH_LOG2 (1..8).
REQ-003 SHALL have parameter AF_LEVEL, default DEPTH-1, almost_full threshold in entries.
REQ-004 SHALL have parameter AE_LEVEL, default 1, almost_empty threshold in entries.
REQ-005 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port wr_en  input  1  write request.
REQ-008 SHALL have port din  input  DATA_WIDTH  write data.
REQ-009 SHALL have port rd_en  input  1  read request.
REQ-010 SHALL have port dout  output  DATA_WIDTH  registered read data.
REQ-011 SHALL have port full  output  1  count == DEPTH.
REQ-012 SHALL have port empty  output  1  count == 0.
REQ-013 SHALL have port almost_full  output  1  count >= AF_LEVEL.
REQ-014 SHALL have port almost_empty  output  1  count <= AE_LEVEL.
REQ-015 SHALL have port data_count  output  DEPTH_LOG2+1  current occupancy.
REQ-016 SHALL have ports wr_ack, wr_err, rd_ack, rd_err  output  1 each  one-cycle registered status pulses.

Function
REQ-017 SHALL store entries in a DEPTH-entry register array, with wr_ptr and rd_ptr of DEPTH_LOG2 bits that wrap from DEPTH-1 to 0.
REQ-018 SHALL evaluate all accept/reject decisions against the pre-edge count, never the post-edge count.
REQ-019 SHALL accept a write when wr_en=1 and count<DEPTH: mem[wr_ptr]<=din, wr_ptr+1, wr_ack=1 next cycle.
REQ-020 SHALL reject a write when wr_en=1 and count==DEPTH: memory/pointers unchanged, wr_err=1 next cycle.
REQ-021 SHALL accept a read when rd_en=1 and count>0: dout<=mem[rd_ptr] (1-cycle latency), rd_ptr+1, rd_ack=1 next cycle.
REQ-022 SHALL reject a read when rd_en=1 and count==0: dout holds its value, rd_err=1 next cycle.
REQ-023 SHALL, on simultaneous accepted read and write, keep count unchanged and advance both pointers.
REQ-024 SHALL, with wr_en=rd_en=1 at count==DEPTH, accept the read and reject the write (count becomes DEPTH-1).
REQ-025 SHALL, with wr_en=rd_en=1 at count==0, accept the write and reject the read (count becomes 1; read is not bypassed).
REQ-026 SHALL increment count by 1 on write-only accept and decrement by 1 on read-only accept, saturating only via REQ-020/022.
REQ-027 SHALL drive full, empty, almost_full, almost_empty combinationally from the registered count.
REQ-028 SHALL deassert each ack/err pulse in any cycle without the corresponding request; ack and err of one port are never both 1.
REQ-029 SHALL hold dout between accepted reads.

Reset
REQ-030 SHALL, while reset=1 (asynchronously, regardless of clk), force wr_ptr=0, rd_ptr=0, data_count=0, dout=0, and all ack/err=0.
REQ-031 SHALL, during reset, show empty=1, full=0, almost_empty=1, almost_full per REQ-013 at count 0.
REQ-032 SHALL not reset memory contents; they are unobservable until rewritten.
REQ-033 SHALL, on reset asserted mid-operation, discard all stored entries and ignore wr_en/rd_en until reset deasserts.

Verification (DATA_WIDTH=32, DEPTH_LOG2=3, AF_LEVEL=7, AE_LEVEL=1)
REQ-034 SHALL cover: reset, 8 writes 0x00000001..0x00000008 -> wr_ack each cycle, count 8, full=1, almost_full=1 from count 7.
REQ-035 SHALL cover: 9th write 0xDEADBEEF when full -> wr_err=1, count stays 8; then 8 reads -> dout 1..8 in order, each one cycle after rd_en, empty=1 at end.
REQ-036 SHALL cover: read at empty -> rd_err=1, dout holds 0x00000008, count 0.
REQ-037 SHALL cover: 12 write/read cycles with count=3 -> pointers wrap past 7, count stays 3, data order preserved.
REQ-038 SHALL cover: wr_en=rd_en=1 at full -> rd_ack=1, wr_err=1, count 7; same at empty -> wr_ack=1, rd_err=1, count 1.
REQ-039 SHALL cover: reset asserted mid-clock at count 5 -> count=0, dout=0, empty=1 immediately, before next clk edge.
